// File: rtl/lab_chroma_limiter.sv
// Two-stage elastic clamp for gain-boosted CIE a*/b* pairs, with per-frame
// clipped-pixel statistics reported on each frame's final beat.
module lab_chroma_limiter #(
    parameter int unsigned W     = 32,
    parameter int          A_MIN = -139793,
    parameter int          A_MAX = 159299,
    parameter int          B_MIN = -175554,
    parameter int          B_MAX = 152797
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_last,
    input  logic signed [W-1:0] CIEa_in,
    input  logic signed [W-1:0] CIEb_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic signed [W-1:0] CIEa_out,
    output logic signed [W-1:0] CIEb_out,
    output logic [15:0]         clip_count,
    output logic                clip_count_valid
);

    localparam int unsigned CW = 16;
    localparam logic signed [W-1:0] A_LO = W'(A_MIN);
    localparam logic signed [W-1:0] A_HI = W'(A_MAX);
    localparam logic signed [W-1:0] B_LO = W'(B_MIN);
    localparam logic signed [W-1:0] B_HI = W'(B_MAX);

    logic                s1_valid;
    logic signed [W-1:0] s1_a;
    logic signed [W-1:0] s1_b;
    logic                s1_last;
    logic                s1_a_lo, s1_a_hi, s1_b_lo, s1_b_hi;
    logic                s2_clip;
    logic [CW-1:0]       clip_cnt;

    logic                s1_adv;
    logic                in_xfer;
    logic                out_xfer;
    logic [CW-1:0]       clip_sum;

    // Handshake: S2 frees when empty or draining, S1 follows it.
    always_comb begin
        s1_adv   = !out_valid || out_ready;
        in_ready = !s1_valid || s1_adv;
        in_xfer  = in_valid && in_ready;
        out_xfer = out_valid && out_ready;
        clip_sum = clip_cnt;
        if (s2_clip && (clip_cnt != {CW{1'b1}})) begin
            clip_sum = clip_cnt + CW'(1);
        end
    end

    // S1: capture sample and range flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_last  <= 1'b0;
            s1_a_lo  <= 1'b0;
            s1_a_hi  <= 1'b0;
            s1_b_lo  <= 1'b0;
            s1_b_hi  <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_xfer) begin
                s1_a    <= CIEa_in;
                s1_b    <= CIEb_in;
                s1_last <= in_last;
                s1_a_lo <= CIEa_in < A_LO;
                s1_a_hi <= CIEa_in > A_HI;
                s1_b_lo <= CIEb_in < B_LO;
                s1_b_hi <= CIEb_in > B_HI;
            end
        end
    end

    // S2: select bound or pass-through; holds while stalled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            CIEa_out  <= '0;
            CIEb_out  <= '0;
            out_last  <= 1'b0;
            s2_clip   <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                CIEa_out <= s1_a_lo ? A_LO : (s1_a_hi ? A_HI : s1_a);
                CIEb_out <= s1_b_lo ? B_LO : (s1_b_hi ? B_HI : s1_b);
                out_last <= s1_last;
                s2_clip  <= s1_a_lo | s1_a_hi | s1_b_lo | s1_b_hi;
            end
        end
    end

    // Per-frame clip statistics, counted on output beats.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clip_cnt         <= '0;
            clip_count       <= '0;
            clip_count_valid <= 1'b0;
        end else begin
            clip_count_valid <= 1'b0;
            if (out_xfer) begin
                if (out_last) begin
                    clip_count       <= clip_sum;
                    clip_count_valid <= 1'b1;
                    clip_cnt         <= '0;
                end else begin
                    clip_cnt <= clip_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_lab_chroma_limiter.sv
// Directed bench for lab_chroma_limiter: a queue-based clamp/statistics model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_lab_chroma_limiter;

    localparam int unsigned W = 32;
    localparam int LIM_A_MIN = -139793;
    localparam int LIM_A_MAX = 159299;
    localparam int LIM_B_MIN = -175554;
    localparam int LIM_B_MAX = 152797;

    logic                clock = 1'b0;
    logic                reset_n;
    logic                in_valid;
    logic                in_ready;
    logic                in_last;
    logic signed [W-1:0] CIEa_in;
    logic signed [W-1:0] CIEb_in;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;
    logic signed [W-1:0] CIEa_out;
    logic signed [W-1:0] CIEb_out;
    logic [15:0]         clip_count;
    logic                clip_count_valid;

    lab_chroma_limiter #(
        .W(W), .A_MIN(LIM_A_MIN), .A_MAX(LIM_A_MAX), .B_MIN(LIM_B_MIN), .B_MAX(LIM_B_MAX)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .CIEa_in(CIEa_in), .CIEb_in(CIEb_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .CIEa_out(CIEa_out), .CIEb_out(CIEb_out),
        .clip_count(clip_count), .clip_count_valid(clip_count_valid)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int   a;
        int   b;
        logic last;
    } samp_t;

    samp_t q[$];
    int    cnt_m    = 0;
    bit    pend     = 1'b0;
    int    pend_val = 0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int limit(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Reference model and per-cycle compare, sampled on the falling edge.
    always @(negedge clock) begin
        if (!reset_n) begin
            q.delete();
            cnt_m = 0;
            pend  = 1'b0;
        end else begin
            check("clip_count_valid", 64'(clip_count_valid), 64'(pend));
            if (pend) check("clip_count_model", 64'(clip_count), 64'(pend_val));
            pend = 1'b0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_output: actual a=%0d b=%0d, required no beat", CIEa_out, CIEb_out);
                end else begin
                    samp_t s;
                    int ea, eb;
                    s  = q.pop_front();
                    ea = limit(s.a, LIM_A_MIN, LIM_A_MAX);
                    eb = limit(s.b, LIM_B_MIN, LIM_B_MAX);
                    check("out_a", 64'(CIEa_out), 64'(ea));
                    check("out_b", 64'(CIEb_out), 64'(eb));
                    check("out_last", 64'(out_last), 64'(s.last));
                    if (ea != s.a || eb != s.b) cnt_m = (cnt_m < 65535) ? cnt_m + 1 : 65535;
                    if (s.last) begin
                        pend     = 1'b1;
                        pend_val = cnt_m;
                        cnt_m    = 0;
                    end
                end
            end
            if (in_valid && in_ready) begin
                samp_t s;
                s.a    = CIEa_in;
                s.b    = CIEb_in;
                s.last = in_last;
                q.push_back(s);
            end
        end
    end

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    endtask

    task automatic send(input int a, input int b, input logic last);
        int   guard;
        logic ok;
        in_valid = 1'b1;
        CIEa_in  = W'(a);
        CIEb_in  = W'(b);
        in_last  = last;
        guard    = 0;
        forever begin
            @(negedge clock);
            ok = in_ready;
            @(posedge clock);
            #1;
            if (ok) break;
            guard++;
            if (guard > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: in_ready actual 0, required 1 within 200 cycles");
                summary();
                $fatal(1, "in_ready stuck low");
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_cv(input string name, input int exp);
        bit found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (clip_count_valid) begin
                check(name, 64'(clip_count), 64'(exp));
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: clip_count_valid actual 0, required 1 within 20 cycles", name);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        #1_500_000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time actual exceeded, required completion");
        summary();
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        CIEa_in   = '0;
        CIEb_in   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_a", 64'(CIEa_out), 0);
        check("rst_b", 64'(CIEb_out), 0);
        check("rst_last", 64'(out_last), 0);
        check("rst_clip_count", 64'(clip_count), 0);
        check("rst_clip_valid", 64'(clip_count_valid), 0);
        reset_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 1);

        // Pass-through and two-cycle latency
        send(57217, 30397, 1'b0);
        check("lat_early_valid", 64'(out_valid), 0);
        @(posedge clock);
        #1;
        check("pass_valid", 64'(out_valid), 1);
        check("pass_a", 64'(CIEa_out), 57217);
        check("pass_b", 64'(CIEb_out), 30397);

        // Clamp, then inclusive bounds; closes a frame with one clip
        send(200000, -200000, 1'b0);
        @(posedge clock);
        #1;
        check("clamp_a", 64'(CIEa_out), 159299);
        check("clamp_b", 64'(CIEb_out), -175554);
        send(-139793, 152797, 1'b1);
        @(posedge clock);
        #1;
        check("bound_a", 64'(CIEa_out), -139793);
        check("bound_b", 64'(CIEb_out), 152797);
        check("bound_last", 64'(out_last), 1);
        wait_cv("clamp_frame_count", 1);

        // 10-pixel frame with pixels 2, 5, 9 out of range
        for (int i = 0; i < 10; i++) begin
            int a, b;
            a = i * 1000;
            b = -i * 500;
            if (i == 2) a = 300000;
            if (i == 5) b = -300000;
            if (i == 9) a = -150000;
            send(a, b, 1'(i == 9));
        end
        wait_cv("frame10_count", 3);
        for (int i = 0; i < 4; i++) send(i * 7, -i * 11, 1'(i == 3));
        wait_cv("frame4_count", 0);

        // Back-pressure: stall 5 cycles from the start of an 8-sample stream
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        fork
            for (int k = 0; k < 8; k++) send((k % 2 == 1) ? 170000 : 1000 + k, -k, 1'(k == 7));
            begin
                repeat (2) @(posedge clock);
                #1;
                check("bp_in_ready_low", 64'(in_ready), 0);
                check("bp_head_a", 64'(CIEa_out), 1000);
                repeat (3) @(posedge clock);
                #1;
                out_ready = 1'b1;
                #1;
                check("bp_release_in_ready", 64'(in_ready), 1);
            end
        join
        wait_cv("bp_frame_count", 4);
        check("bp_drained", 64'(q.size()), 0);

        // Counter saturation
        for (int i = 0; i < 70000; i++) send(200000, 0, 1'b0);
        send(0, 0, 1'b1);
        wait_cv("sat_count", 65535);

        // Reset mid-frame with both stages full
        send(200000, 0, 1'b0);
        send(0, -200000, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        out_ready = 1'b0;
        send(1, 1, 1'b0);
        send(2, 2, 1'b0);
        check("prerst_full", 64'(out_valid), 1);
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 0);
        check("midrst_a", 64'(CIEa_out), 0);
        check("midrst_b", 64'(CIEb_out), 0);
        check("midrst_last", 64'(out_last), 0);
        check("midrst_clip_count", 64'(clip_count), 0);
        @(posedge clock);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        send(5, 5, 1'b0);
        send(200000, 7, 1'b0);
        send(9, 9, 1'b1);
        wait_cv("post_rst_count", 1);

        repeat (5) @(posedge clock);
        #1;
        check("final_drained", 64'(q.size()), 0);
        summary();
        $finish;
    end

endmodule

// File: doc/lab_chroma_limiter.md
# lab_chroma_limiter

Pipelined clamp stage directly downstream of the saturation enhancement stage. It accepts gain-boosted CIE a*/b* pairs, clamps each component into the legal gamut window, and forwards them with a valid/ready handshake. It also counts clipped pixels per frame and reports the count at each frame end. The ×1.1 chroma gain upstream can push samples past the a*/b* range, so this stage bounds them before the Lab→XYZ conversion that follows.

## Interface
Parameters:
- W, default 32: width of the signed a*/b* data, equal to `size_int.
- A_MIN, default -139793: lower a* bound, scaled units (-86 × 256 × 6.3496).
- A_MAX, default 159299: upper a* bound (98 × 256 × 6.3496).
- B_MIN, default -175554: lower b* bound (-108 × 256 × 6.3496).
- B_MAX, default 152797: upper b* bound (94 × 256 × 6.3496).

Ports:
- clock  in  1  single clock; all registers update on the rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  input sample present.
- in_ready  out  1  stage can accept a sample this cycle.
- in_last  in  1  marks the final pixel of a frame; qualified by in_valid.
- CIEa_in  in  W signed  enhanced a*.
- CIEb_in  in  W signed  enhanced b*.
- out_valid  out  1  output sample present.
- out_ready  in  1  downstream accepts the sample.
- out_last  out  1  in_last delayed alongside its sample.
- CIEa_out  out  W signed  clamped a*.
- CIEb_out  out  W signed  clamped b*.
- clip_count  out  16  clipped-pixel count of the last completed frame.
- clip_count_valid  out  1  one-cycle strobe when clip_count updates.

## Operation
- Two-stage elastic pipeline, S1 then S2. Each stage has a valid bit.
- A stage loads when it is empty or when its contents leave in the same cycle.
- in_ready = !S1.valid || S1 advances.
- S1 advances when !S2.valid || out_ready.
- An input transfer happens when in_valid && in_ready.
- S1 registers a, b and last. It also registers four compare flags: a<A_MIN, a>A_MAX, b<B_MIN, b>B_MAX. All compares are signed, at W bits.
- S2 registers the clamped values:
  - a' = A_MIN if a<A_MIN; A_MAX if a>A_MAX; otherwise a. Same rule for b.
  - S2 also registers clip = OR of the four flags, and last.
- Outputs CIEa_out, CIEb_out, out_last and out_valid are driven directly from S2 registers.
- No arithmetic beyond comparison. Values inside the window, including values equal to a bound, pass through bit-exact.
- Clip counter, 16 bits internal:
  - It updates only on an output transfer (out_valid && out_ready).
  - It increments by 1 when that beat has clip set, and saturates at 0xFFFF.
  - On a transfer with out_last=1: clip_count takes counter + clip (saturated), clip_count_valid pulses high for 1 cycle, and the internal counter clears to 0.
  - The pulse applies to this final beat only.
- While out_valid=1 and out_ready=0, the S2 data, last and clip bits stay stable until the transfer.
- Reset state: S1.valid=0, S2.valid=0, and the internal counter=0.
- Output reset values: out_valid=0, CIEa_out=0, CIEb_out=0, out_last=0, clip_count=0, clip_count_valid=0. in_ready reads 1 once reset_n is high.
- Reset asserted mid-frame discards both pipeline entries and the partial count. Nothing is emitted for the lost samples.

## Timing
- Latency: a sample accepted on cycle N appears on out_valid at cycle N+2 when out_ready is held high.
- Throughput: 1 sample per cycle with out_ready=1.
- Back-pressure:
  - With out_ready=0, at most 2 samples are buffered.
  - in_ready falls in the cycle after S1 fills while S2 is stalled.
- Release: when out_ready returns to 1, S2 drains and S1 moves to S2 in the same cycle. in_ready is high that cycle, so no bubble is inserted.
- Counter boundary: a clipped final-pixel beat contributes to the count reported on that same beat.
- Timing of clip_count: it is valid in the cycle after the final transfer, coincident with clip_count_valid=1.
- Consecutive single-pixel frames produce consecutive clip_count_valid pulses.

## Test plan
- Pass-through: a=57217, b=30397, out_ready=1 -> same values on the output 2 cycles later; clip=0.
- Clamp: (a=200000, b=-200000) -> (159299, -175554). Then (a=-139793, b=152797) -> unchanged, because bounds are inclusive.
- Frame stats: 10-pixel frame with pixels 2, 5 and 9 out of range, last on pixel 9 -> clip_count=3 with one clip_count_valid pulse. A following 4-pixel frame with all pixels in range -> clip_count=0.
- Back-pressure: stream 8 samples, hold out_ready=0 for 5 cycles mid-stream -> in_ready drops after 2 buffered samples. Output order and values are intact and no sample is duplicated or dropped.
- Saturation: 70000 clipped pixels, then last -> clip_count=0xFFFF.
- Reset mid-frame: pull reset_n low with both stages full -> out_valid=0 immediately and all outputs are 0. A new 3-pixel frame with 1 clipped pixel -> clip_count=1.
